// File: rtl/cond_flag_unit_if.sv
// ---------------------------------------------------------------------------
// cond_flag_unit_if
// Bundles the decoder/ALU-facing signals of cond_flag_unit.
//   master : decoder/ALU side; drives instruction info, receives enables
//   slave  : cond_flag_unit; consumes instruction info, drives enables/state
// Signals:
//   valid_i   instruction present this cycle
//   Cond      4-bit condition field
//   ALUFlags  ALU flags {N,Z,C,V}
//   FlagW     [1] update N,Z ; [0] update C,V
//   PCS/RegW/MemW/NoWrite  decoder controls
//   PCSrc/RegWrite/MemWrite gated enables
//   Flags     architectural flag register {N,Z,C,V}
//   cond_err  sticky illegal-condition indicator
//   ovf_cnt   saturating count of executed V-setting updates (CNT_W bits)
// ---------------------------------------------------------------------------
interface cond_flag_unit_if #(
   parameter int CNT_W = 8
);
   logic             valid_i;
   logic [3:0]       Cond;
   logic [3:0]       ALUFlags;
   logic [1:0]       FlagW;
   logic             PCS;
   logic             RegW;
   logic             MemW;
   logic             NoWrite;
   logic             PCSrc;
   logic             RegWrite;
   logic             MemWrite;
   logic [3:0]       Flags;
   logic             cond_err;
   logic [CNT_W-1:0] ovf_cnt;

   modport master (
      output valid_i, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
      input  PCSrc, RegWrite, MemWrite, Flags, cond_err, ovf_cnt
   );

   modport slave (
      input  valid_i, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
      output PCSrc, RegWrite, MemWrite, Flags, cond_err, ovf_cnt
   );
endinterface

// File: rtl/cond_flag_unit.sv
// ---------------------------------------------------------------------------
// cond_flag_unit
// Holds the NZCV flag register, evaluates the ARM-style condition field
// against it, gates the decoder write/branch enables and updates the flags
// from the ALU when the instruction executes.
// Ports:
//   clk    system clock, rising-edge state updates
//   reset  asynchronous active-high reset, clears all state
//   bus    cond_flag_unit_if.slave (see interface file for signal list)
// Optional feature:
//   COND_FLAG_OVF_CNT_EN  when defined, ovf_cnt is a saturating counter of
//   executed flag updates that write V=1; when undefined, ovf_cnt is tied 0.
// ---------------------------------------------------------------------------
module cond_flag_unit #(
   parameter int CNT_W = 8
) (
   input  logic           clk,
   input  logic           reset,
   cond_flag_unit_if.slave bus
);

   logic [3:0] flags_r;
   logic       cond_err_r;
   logic       cond_pass_s;
   logic       cond_ex_s;
   logic       exec_s;

   // Condition-field evaluation against a {N,Z,C,V} flag vector.
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
      logic n;
      logic z;
      logic c;
      logic v;
      logic res;
      n = flags[3];
      z = flags[2];
      c = flags[1];
      v = flags[0];
      case (cond)
         4'b0000: res = z;
         4'b0001: res = ~z;
         4'b0010: res = c;
         4'b0011: res = ~c;
         4'b0100: res = n;
         4'b0101: res = ~n;
         4'b0110: res = v;
         4'b0111: res = ~v;
         4'b1000: res = c & ~z;
         4'b1001: res = ~c | z;
         4'b1010: res = (n == v);
         4'b1011: res = (n != v);
         4'b1100: res = ~z & (n == v);
         4'b1101: res = z | (n != v);
         4'b1110: res = 1'b1;
         4'b1111: res = 1'b0;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Condition decision uses the registered flags so an instruction never
   // sees its own update; the valid gate keeps don't-care inputs harmless.
   always_comb begin
      cond_pass_s = 1'b0;
      cond_ex_s   = 1'b0;
      exec_s      = 1'b0;
      if (bus.valid_i) begin
         cond_pass_s = cond_eval(bus.Cond, flags_r);
      end else begin
         cond_pass_s = 1'b0;
      end
      cond_ex_s = bus.valid_i & cond_pass_s;
      // Enables are additionally masked by reset so nothing leaks out while
      // the flag register is being cleared.
      exec_s    = cond_ex_s & ~reset;
   end

   assign bus.PCSrc    = bus.PCS & exec_s;
   assign bus.RegWrite = bus.RegW & ~bus.NoWrite & exec_s;
   assign bus.MemWrite = bus.MemW & exec_s;
   assign bus.Flags    = flags_r;
   assign bus.cond_err = cond_err_r;

   // Flag register: N,Z and C,V halves update independently when executed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_r <= 4'b0000;
      end else begin
         if (cond_ex_s && bus.FlagW[1]) begin
            flags_r[3:2] <= bus.ALUFlags[3:2];
         end
         if (cond_ex_s && bus.FlagW[0]) begin
            flags_r[1:0] <= bus.ALUFlags[1:0];
         end
      end
   end

   // Sticky flag for a valid instruction carrying the reserved condition.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cond_err_r <= 1'b0;
      end else if (bus.valid_i && (bus.Cond == 4'b1111)) begin
         cond_err_r <= 1'b1;
      end
   end

`ifdef COND_FLAG_OVF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] ovf_cnt_r;
   logic             ovf_inc_s;

   assign ovf_inc_s = cond_ex_s & bus.FlagW[0] & bus.ALUFlags[0];

   // Debug counter of executed updates that write V=1; holds at all-ones.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_cnt_r <= {CNT_W{1'b0}};
      end else if (ovf_inc_s && (ovf_cnt_r != CNT_MAX)) begin
         ovf_cnt_r <= ovf_cnt_r + CNT_ONE;
      end
   end

   assign bus.ovf_cnt = ovf_cnt_r;
`else
   assign bus.ovf_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_cond_flag_unit
// Scoreboard bench: the driver pushes the expected outputs of every cycle
// computed from a behavioural flag/condition model; a monitor pops and
// compares on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_cond_flag_unit;

   localparam int CNT_W = 2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   cond_flag_unit_if #(.CNT_W(CNT_W)) bus ();

   cond_flag_unit #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic       pcsrc;
      logic       regwrite;
      logic       memwrite;
      logic [3:0] flags;
      logic       cond_err;
      int         ovf;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   sample = 0;

   // Reference state
   bit [3:0] m_flags;
   bit       m_err;
   int       m_cnt;

   // Condition rules: even codes are a base predicate, odd codes its
   // complement; 1111 never executes.
   function automatic bit model_cond(input bit [3:0] c, input bit [3:0] f);
      bit n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      if (c == 4'd15) return 1'b0;
      case (int'(c) / 2)
         0: base = z;
         1: base = cy;
         2: base = n;
         3: base = v;
         4: base = cy && !z;
         5: base = (n == v);
         6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return base ^ c[0];
   endfunction

   task automatic cmp(input string name, input int cyc, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s sample %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Monitor: compare whatever the driver queued for this cycle.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         sample++;
         cmp("PCSrc",    sample, int'(bus.PCSrc),    int'(e.pcsrc));
         cmp("RegWrite", sample, int'(bus.RegWrite), int'(e.regwrite));
         cmp("MemWrite", sample, int'(bus.MemWrite), int'(e.memwrite));
         cmp("Flags",    sample, int'(bus.Flags),    int'(e.flags));
         cmp("cond_err", sample, int'(bus.cond_err), int'(e.cond_err));
         cmp("ovf_cnt",  sample, int'(bus.ovf_cnt),  e.ovf);
      end
   end

   // Drive one cycle, queue its expectation, advance the model at the edge.
   task automatic step(input bit v, input bit [3:0] c, input bit [3:0] a,
                       input bit [1:0] fw, input bit pcs, input bit regw,
                       input bit memw, input bit nw);
      exp_t e;
      bit   ex;
      bus.valid_i  = v;
      bus.Cond     = c;
      bus.ALUFlags = a;
      bus.FlagW    = fw;
      bus.PCS      = pcs;
      bus.RegW     = regw;
      bus.MemW     = memw;
      bus.NoWrite  = nw;
      ex = v && model_cond(c, m_flags) && !reset;
      e.pcsrc    = pcs && ex;
      e.regwrite = regw && !nw && ex;
      e.memwrite = memw && ex;
      e.flags    = m_flags;
      e.cond_err = m_err;
`ifdef COND_FLAG_OVF_CNT_EN
      e.ovf      = m_cnt;
`else
      e.ovf      = 0;
`endif
      sb_q.push_back(e);
      @(posedge clk);
      if (!reset) begin
         if (ex && fw[1]) m_flags[3:2] = a[3:2];
         if (ex && fw[0]) m_flags[1:0] = a[1:0];
         if (v && c == 4'd15) m_err = 1'b1;
         if (ex && fw[0] && a[0] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      #1;
   endtask

   // Reset asserted mid-cycle with inputs that would otherwise update state.
   task automatic apply_reset(input int n);
      reset   = 1'b1;
      m_flags = 4'b0000;
      m_err   = 1'b0;
      m_cnt   = 0;
      repeat (n) step(1'b1, 4'b1110, 4'($urandom), 2'b11, 1'b1, 1'b1, 1'b1, 1'b0);
      reset = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 4'($urandom), 4'($urandom), 2'($urandom), 1'b1, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      bus.valid_i = 1'b0; bus.Cond = 4'b0000; bus.ALUFlags = 4'b0000;
      bus.FlagW = 2'b00; bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0;
      bus.NoWrite = 1'b0;
      m_flags = 4'b0000; m_err = 1'b0; m_cnt = 0;
      @(posedge clk);
      #1;

      // Reset then idle
      apply_reset(2);
      idle();

      // ALU 7-3: C set, then CS executes and EQ does not
      step(1'b1, 4'b1110, 4'b0010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'b0010, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

      // ALU 0-3: partial N,Z update keeps C; LT true, GE false
      step(1'b1, 4'b1110, 4'b1000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 4'b1011, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 4'b1010, 4'b0000, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0);

      // Suppressed instruction leaves flags alone
      apply_reset(1);
      step(1'b1, 4'b0000, 4'b0100, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0);
      idle();

      // Illegal condition sets sticky error; NoWrite blocks RegWrite
      step(1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      idle();
      step(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
      idle();

      // Counter saturation: five executed V-setting updates
      apply_reset(1);
      repeat (5) step(1'b1, 4'b1110, 4'b0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      idle();

      // Randomised traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            apply_reset(1);
         end else begin
            step(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom));
         end
      end
      idle();

      // Drain the scoreboard with a bounded wait
      for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
